// File: rtl/load_size_ctrl.sv
// load_size_ctrl: issues one aligned word read per load, then extracts and extends the addressed byte/halfword/word
module load_size_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] mem_data,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] out
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic [1:0] lane, sz;
  logic sx, illegal, accept, mem_read_d, busy_d, done_d, err_d;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ext;
  assign illegal = size == 2'b00 || (size == 2'b10 && addr[0]) || (size == 2'b11 && addr[1:0] != 2'b00);
  assign accept = state == IDLE && start && !illegal;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (illegal ? ERR : REQ) : IDLE;
      REQ:     nxt = WAIT;
      WAIT:    nxt = cnt == 4'd0 ? DONE : WAIT;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered, so they are derived from the state being entered
  always_comb begin
    mem_read_d = nxt == REQ;
    busy_d = nxt != IDLE;
    done_d = nxt == DONE || nxt == ERR;
    err_d = nxt == ERR;
  end
  always_comb begin
    b = mem_data[{lane, 3'b000} +: 8];
    h = lane[1] ? mem_data[31:16] : mem_data[15:0];
    ext = sz == 2'b01 ? {{24{sx & b[7]}}, b} : sz == 2'b10 ? {{16{sx & h[15]}}, h} : mem_data;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      lane <= 2'b00;
      sz <= 2'b00;
      sx <= 1'b0;
      mem_addr <= 32'd0;
      mem_read <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      out <= 32'd0;
    end else begin
      state <= nxt;
      mem_read <= mem_read_d;
      busy <= busy_d;
      done <= done_d;
      err <= err_d;
      if (accept) begin
        sz <= size;
        sx <= sign_ext;
        lane <= addr[1:0];
        mem_addr <= {addr[31:2], 2'b00};
      end
      if (state == REQ) cnt <= 4'(MEM_LATENCY - 1);
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == WAIT && cnt == 4'd0) out <= ext;
    end
  end
endmodule

// File: tb/tb_load_size_ctrl.sv
// tb_load_size_ctrl: vector table plus corner sequences for load_size_ctrl at latency 1 and 4
module tb_load_size_ctrl;
  logic clock = 0, reset = 1, start1 = 0, start4 = 0, sign_ext = 0;
  logic [1:0] size = 2'b00;
  logic [31:0] addr = 0, md1 = 0, md4 = 0;
  logic [31:0] mem_addr1, out1, mem_addr4, out4;
  logic mem_read1, busy1, done1, err1, mem_read4, busy4, done4, err4;
  int tests = 0, failed = 0;
  logic [32:0] exp_q[$];
  typedef struct {
    logic [1:0]  size;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] md;
    logic [31:0] out;
    logic        err;
  } vec_t;
  vec_t vecs[12];

  always #5 clock = ~clock;

  load_size_ctrl #(.MEM_LATENCY(1)) d1 (
    .clock(clock), .reset(reset), .start(start1), .size(size), .sign_ext(sign_ext),
    .addr(addr), .mem_data(md1), .mem_addr(mem_addr1), .mem_read(mem_read1),
    .busy(busy1), .done(done1), .err(err1), .out(out1));

  load_size_ctrl #(.MEM_LATENCY(4)) d4 (
    .clock(clock), .reset(reset), .start(start4), .size(size), .sign_ext(sign_ext),
    .addr(addr), .mem_data(md4), .mem_addr(mem_addr4), .mem_read(mem_read4),
    .busy(busy4), .done(done4), .err(err4), .out(out4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic run1(input vec_t v, input string tag);
    int k, reads;
    logic [32:0] e;
    @(negedge clock);
    check({tag, " idle done"}, {31'd0, done1}, 32'd0);
    check({tag, " idle busy"}, {31'd0, busy1}, 32'd0);
    size = v.size; sign_ext = v.sx; addr = v.addr; md1 = v.md; start1 = 1;
    exp_q.push_back({v.err, v.out});
    reads = 0;
    for (k = 1; k <= 12; k++) begin
      @(negedge clock);
      start1 = 0;
      if (mem_read1) reads++;
      if (done1) break;
    end
    e = exp_q.pop_front();
    check({tag, " latency"}, 32'(k), v.err ? 32'd1 : 32'd3);
    check({tag, " out"}, out1, e[31:0]);
    check({tag, " err"}, {31'd0, err1}, {31'd0, e[32]});
    check({tag, " reads"}, 32'(reads), v.err ? 32'd0 : 32'd1);
    check({tag, " busy at done"}, {31'd0, busy1}, 32'd1);
    if (!v.err) check({tag, " mem_addr"}, mem_addr1, {v.addr[31:2], 2'b00});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, reads, dones;
    logic [32:0] e;
    vecs[0]  = '{2'b01, 1'b1, 32'h103, 32'h80FF7F01, 32'hFFFFFF80, 1'b0};
    vecs[1]  = '{2'b01, 1'b0, 32'h103, 32'h80FF7F01, 32'h00000080, 1'b0};
    vecs[2]  = '{2'b01, 1'b1, 32'h101, 32'h80FF7F01, 32'h0000007F, 1'b0};
    vecs[3]  = '{2'b01, 1'b1, 32'h102, 32'h80FF7F01, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{2'b10, 1'b1, 32'h042, 32'h80017FFE, 32'hFFFF8001, 1'b0};
    vecs[5]  = '{2'b10, 1'b1, 32'h040, 32'h80017FFE, 32'h00007FFE, 1'b0};
    vecs[6]  = '{2'b10, 1'b0, 32'h042, 32'h80017FFE, 32'h00008001, 1'b0};
    vecs[7]  = '{2'b11, 1'b1, 32'h200, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[8]  = '{2'b11, 1'b0, 32'h202, 32'h12345678, 32'hDEADBEEF, 1'b1};
    vecs[9]  = '{2'b10, 1'b0, 32'h001, 32'h12345678, 32'hDEADBEEF, 1'b1};
    vecs[10] = '{2'b00, 1'b0, 32'h000, 32'h12345678, 32'hDEADBEEF, 1'b1};
    vecs[11] = '{2'b01, 1'b0, 32'h100, 32'h80FF7F01, 32'h00000001, 1'b0};

    #2 reset = 0;
    #1;
    check("reset out", out1, 32'd0);
    check("reset mem_addr", mem_addr1, 32'd0);
    check("reset mem_read", {31'd0, mem_read1}, 32'd0);
    check("reset busy", {31'd0, busy1}, 32'd0);
    check("reset done", {31'd0, done1}, 32'd0);
    check("reset err", {31'd0, err1}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1;

    for (int i = 0; i < 12; i++) run1(vecs[i], $sformatf("vec%0d", i));

    // latency 4 word load with garbage outside the sampling cycle
    @(negedge clock);
    size = 2'b11; sign_ext = 1; addr = 32'h200; start4 = 1; md4 = $urandom & 32'h0000FFFF;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    reads = 0;
    for (k = 1; k <= 12; k++) begin
      @(negedge clock);
      start4 = 0;
      if (mem_read4) reads++;
      if (done4) break;
      md4 = (k == 5) ? 32'hDEADBEEF : ($urandom & 32'h0000FFFF);
    end
    e = exp_q.pop_front();
    check("lat4 latency", 32'(k), 32'd6);
    check("lat4 out", out4, e[31:0]);
    check("lat4 err", {31'd0, err4}, {31'd0, e[32]});
    check("lat4 reads", 32'(reads), 32'd1);
    check("lat4 mem_addr", mem_addr4, 32'h200);

    // start pulsed while busy must be ignored
    @(negedge clock);
    size = 2'b01; sign_ext = 1; addr = 32'h103; md1 = 32'h80FF7F01; start1 = 1;
    exp_q.push_back({1'b0, 32'hFFFFFF80});
    reads = 0; dones = 0;
    for (k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (mem_read1) reads++;
      if (done1) begin
        dones++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("busy out", out1, e[31:0]);
          check("busy err", {31'd0, err1}, {31'd0, e[32]});
        end
      end
      start1 = (k == 2);
      if (k == 2) begin size = 2'b10; sign_ext = 0; addr = 32'h40; end
    end
    check("busy reads", 32'(reads), 32'd1);
    check("busy dones", 32'(dones), 32'd1);
    check("busy mem_addr", mem_addr1, 32'h100);

    // reset during an active load
    @(negedge clock);
    size = 2'b11; addr = 32'h300; md4 = 32'h55AA55AA; start4 = 1;
    @(negedge clock);
    start4 = 0;
    check("midreset read before", {31'd0, mem_read4}, 32'd1);
    reset = 0;
    #1;
    check("midreset mem_read", {31'd0, mem_read4}, 32'd0);
    check("midreset busy", {31'd0, busy4}, 32'd0);
    check("midreset out", out4, 32'd0);
    check("midreset mem_addr", mem_addr4, 32'd0);
    check("midreset done", {31'd0, done4}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1;
    dones = 0;
    for (k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done4) dones++;
    end
    check("midreset dones after", 32'(dones), 32'd0);
    check("midreset busy after", {31'd0, busy4}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
